// File: rtl/pe_pkg.sv
// pe_pkg: shared state enumeration and pixel constants for pe_ctrl.
// The ERR state exists only when PE_CTRL_TIMEOUT_EN is defined.
package pe_pkg;
  localparam int PIX_W = 8;
  localparam int SAT_MAX = 255;
  typedef enum logic [3:0] {
    IDLE, SUM_START, SUM_WAIT, SUM_ACK, CALC, BG_START, BG_WAIT, BG_ACK
`ifdef PE_CTRL_TIMEOUT_EN
    , ERR
`endif
  } state_t;
endpackage

// File: rtl/pe_avg.sv
// pe_avg: channel average as a right shift of the pixel sum, saturated to one pixel.
module pe_avg import pe_pkg::*; #(
  parameter int W = 32,
  parameter int SHIFT = 2
) (
  input  logic [W-1:0]     sum,
  output logic [PIX_W-1:0] avg
);
  logic [W-1:0] q;
  assign q = sum >> SHIFT;
  assign avg = (q > W'(SAT_MAX)) ? PIX_W'(SAT_MAX) : q[PIX_W-1:0];
endmodule

// File: rtl/pe_ctrl.sv
// pe_ctrl: sequences a PE through sum, average and background-removal phases.
// Optional wait-state watchdog with ERR state enabled by PE_CTRL_TIMEOUT_EN.
module pe_ctrl import pe_pkg::*; #(
  parameter int NUM_PIXELS = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Go,
  input  logic [PIX_W-1:0]            Threshold_in,
  input  logic [PIX_W-1:0]            Bg_r_in,
  input  logic [PIX_W-1:0]            Bg_g_in,
  input  logic [PIX_W-1:0]            Bg_b_in,
  output logic                        Busy,
  output logic                        Done,
  output logic                        Err,
  output logic [PIX_W*NUM_PIXELS-1:0] Result_r,
  output logic [PIX_W*NUM_PIXELS-1:0] Result_g,
  output logic [PIX_W*NUM_PIXELS-1:0] Result_b,
  output logic                        Start_Sum,
  output logic                        Start_BgRemoval,
  output logic                        Ack,
  output logic [PIX_W-1:0]            red_exp,
  output logic [PIX_W-1:0]            green_exp,
  output logic [PIX_W-1:0]            blue_exp,
  output logic [PIX_W-1:0]            threshold,
  output logic [PIX_W-1:0]            desired_bg_r,
  output logic [PIX_W-1:0]            desired_bg_g,
  output logic [PIX_W-1:0]            desired_bg_b,
  input  logic                        Qsd,
  input  logic                        Qbgd,
  input  logic [PIX_W*NUM_PIXELS-1:0] red_sum,
  input  logic [PIX_W*NUM_PIXELS-1:0] green_sum,
  input  logic [PIX_W*NUM_PIXELS-1:0] blue_sum,
  input  logic [PIX_W*NUM_PIXELS-1:0] red_out,
  input  logic [PIX_W*NUM_PIXELS-1:0] green_out,
  input  logic [PIX_W*NUM_PIXELS-1:0] blue_out
);
  localparam int SW = PIX_W * NUM_PIXELS;
  localparam int SH = $clog2(NUM_PIXELS);
  state_t state, state_nxt;
  logic [SW-1:0] r_sum, g_sum, b_sum;
  logic [PIX_W-1:0] r_avg, g_avg, b_avg;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= state_nxt;
`ifdef PE_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic tmo;
  // cnt is zero whenever outside a wait state, so it starts from zero on entry
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) cnt <= '0;
    else cnt <= (state == SUM_WAIT || state == BG_WAIT) ? cnt + CW'(1) : '0;
  assign tmo = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign Err = state == ERR;
`else
  assign Err = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = Go ? SUM_START : IDLE;
      SUM_START: state_nxt = SUM_WAIT;
      SUM_WAIT:  state_nxt = Qsd ? SUM_ACK : SUM_WAIT;
      SUM_ACK:   state_nxt = CALC;
      CALC:      state_nxt = BG_START;
      BG_START:  state_nxt = BG_WAIT;
      BG_WAIT:   state_nxt = Qbgd ? BG_ACK : BG_WAIT;
      default:   state_nxt = IDLE;
    endcase
`ifdef PE_CTRL_TIMEOUT_EN
    if (state == ERR) state_nxt = Go ? IDLE : ERR;
    else if (tmo && ((state == SUM_WAIT && !Qsd) || (state == BG_WAIT && !Qbgd))) state_nxt = ERR;
`endif
  end
  assign Busy = state != IDLE;
  assign Start_Sum = state == SUM_START;
  assign Start_BgRemoval = state == BG_START;
  assign Ack = state == SUM_ACK || state == BG_ACK;
  assign Done = state == BG_ACK;
  pe_avg #(.W(SW), .SHIFT(SH)) u_avg_r (.sum(r_sum), .avg(r_avg));
  pe_avg #(.W(SW), .SHIFT(SH)) u_avg_g (.sum(g_sum), .avg(g_avg));
  pe_avg #(.W(SW), .SHIFT(SH)) u_avg_b (.sum(b_sum), .avg(b_avg));
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      threshold <= '0;
      desired_bg_r <= '0;
      desired_bg_g <= '0;
      desired_bg_b <= '0;
      r_sum <= '0;
      g_sum <= '0;
      b_sum <= '0;
      red_exp <= '0;
      green_exp <= '0;
      blue_exp <= '0;
      Result_r <= '0;
      Result_g <= '0;
      Result_b <= '0;
    end else begin
      if (state == IDLE && Go) begin
        threshold <= Threshold_in;
        desired_bg_r <= Bg_r_in;
        desired_bg_g <= Bg_g_in;
        desired_bg_b <= Bg_b_in;
      end
      if (state == SUM_WAIT && Qsd) begin
        r_sum <= red_sum;
        g_sum <= green_sum;
        b_sum <= blue_sum;
      end
      if (state == CALC) begin
        red_exp <= r_avg;
        green_exp <= g_avg;
        blue_exp <= b_avg;
      end
      if (state == BG_WAIT && Qbgd) begin
        Result_r <= red_out;
        Result_g <= green_out;
        Result_b <= blue_out;
      end
    end
endmodule

// File: doc/pe_ctrl.md
PE_CTRL -- requirements
Module: pe_ctrl

Interface
REQ-001 Parameter NUM_PIXELS, default 4, pixels per processing element; SHALL be a power of two, 1 to 16.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, watchdog limit per wait phase; used only when PE_CTRL_TIMEOUT_EN is defined.
REQ-003 Port Clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port Reset  in  1  reset, asynchronous, active-high.
REQ-005 Port Go  in  1  host start request, sampled only in IDLE.
REQ-006 Port Threshold_in, Bg_r_in, Bg_g_in, Bg_b_in  in  8 each  host threshold and replacement background colour.
REQ-007 Port Busy  out  1  high whenever state is not IDLE.
REQ-008 Port Done  out  1  one-cycle pulse when a run completes.
REQ-009 Port Err  out  1  watchdog error flag; tied 0 when the feature is compiled out.
REQ-010 Port Result_r, Result_g, Result_b  out  8*NUM_PIXELS  captured replaced pixels; pixel i at bits [8i+7:8i].
REQ-011 Port Start_Sum, Start_BgRemoval, Ack  out  1 each  PE command strobes.
REQ-012 Port red_exp, green_exp, blue_exp, threshold, desired_bg_r, desired_bg_g, desired_bg_b  out  8 each  PE operands.
REQ-013 Port Qsd, Qbgd  in  1 each  PE sum-done and bg-done state flags.
REQ-014 Port red_sum, green_sum, blue_sum, red_out, green_out, blue_out  in  8*NUM_PIXELS each  PE results.

Function
REQ-015 States SHALL be IDLE, SUM_START, SUM_WAIT, SUM_ACK, CALC, BG_START, BG_WAIT, BG_ACK, and ERR (ERR only with the macro).
REQ-016 IDLE with Go=1 SHALL go to SUM_START and latch Threshold_in and Bg_*_in onto threshold and desired_bg_*; those latched values SHALL stay stable until the next accepted Go.
REQ-017 SUM_START SHALL assert Start_Sum for exactly one cycle, then go to SUM_WAIT.
REQ-018 SUM_WAIT SHALL hold until Qsd=1, latch red/green/blue_sum in that cycle, then go to SUM_ACK.
REQ-019 SUM_ACK SHALL assert Ack for exactly one cycle, then go to CALC.
REQ-020 CALC SHALL compute each *_exp as latched sum shifted right by log2(NUM_PIXELS), saturated to 255, registered in one cycle, then go to BG_START.
REQ-021 BG_START SHALL assert Start_BgRemoval for one cycle with *_exp already stable, then go to BG_WAIT.
REQ-022 BG_WAIT SHALL hold until Qbgd=1, capture red/green/blue_out into Result_* in that cycle, then go to BG_ACK.
REQ-023 BG_ACK SHALL assert Ack for one cycle and pulse Done in the same cycle, then return to IDLE.
REQ-024 Go while Busy=1 SHALL be ignored and not queued.
REQ-025 Start_Sum, Start_BgRemoval and Ack SHALL never be high in the same cycle.
REQ-026 Qsd or Qbgd arriving in a state other than its own wait state SHALL be ignored.
REQ-027 Latency from Go to Done SHALL be 6 cycles plus the cycles spent in the two wait states.

Reset
REQ-028 Reset=1 SHALL immediately force IDLE; every output SHALL be 0, including Result_*, *_exp, threshold and desired_bg_*.
REQ-029 Reset during a run SHALL abandon it with no Done pulse; any later PE flags SHALL be ignored until a new Go.

Configuration
REQ-030 With PE_CTRL_TIMEOUT_EN defined, a counter SHALL clear on entry to SUM_WAIT and BG_WAIT and increment each cycle spent there.
REQ-031 When the counter reaches TIMEOUT_CYCLES without the awaited flag, the FSM SHALL go to ERR and set Err=1, with no Ack and no Done.
REQ-032 ERR SHALL hold until Go=1, then return to IDLE and clear Err; that Go SHALL NOT start a run.
REQ-033 Without the macro, there SHALL be no counter and no ERR state, Err SHALL be constant 0, and the wait states SHALL wait indefinitely.

Structure
REQ-034 A shared package pe_pkg SHALL hold the state enumeration, PIX_W=8, and the saturation-limit constant 255.
REQ-035 The exp computation SHALL be a sub-module pe_avg: combinational shift plus saturate, instantiated once per channel.

Verification
REQ-036 NUM_PIXELS=4; sums red=387, green=399, blue=594 returned with Qsd -> red_exp=96, green_exp=99, blue_exp=148 in BG_START.
REQ-037 Full run: Go pulse, Qsd after 3 cycles, Qbgd after 5 cycles -> exactly one Start_Sum, one Start_BgRemoval, two Ack pulses; Done pulses in the Ack cycle after Qbgd; Result_* equal the PE outputs present when Qbgd was high.
REQ-038 red_sum=2000 -> red_exp=255 (saturated).
REQ-039 Go re-asserted during SUM_WAIT -> no second Start_Sum; exactly one Done for the run.
REQ-040 Reset asserted in BG_WAIT, then Qbgd=1 -> stays in IDLE, no Done, all outputs 0.
REQ-041 With the macro and TIMEOUT_CYCLES=16, Qsd never asserted -> Err=1 after 16 wait cycles; a following Go clears Err and no Start_Sum follows.
